// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the register file's single write port between the WB stage and a
// long-latency result path. Long-latency results wait in a small FIFO and
// drain into write-port cycles that WB leaves free. The FIFO reports queued
// destinations so decode can stall on RAW hazards.
//
// Optional build macro REGWR_ARB_STARVE_EN: adds a wait counter that forces
// a FIFO grant after MAX_WAIT refused cycles and stalls WB for that cycle.
// Without it WB has fixed priority and the FIFO drains only when WB is idle.
module regfile_wr_arbiter #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_WIDTH      = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int MAX_WAIT       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [REG_WIDTH-1:0]      wb_data,
  output logic                      wb_stall,
  input  logic                      ext_valid,
  output logic                      ext_ready,
  input  logic [REG_ADDR_WIDTH-1:0] ext_rd,
  input  logic [REG_WIDTH-1:0]      ext_data,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  output logic                      pend_hit,
  output logic                      RegWrite,
  output logic [REG_ADDR_WIDTH-1:0] addr_rd,
  output logic [REG_WIDTH-1:0]      data_rd
);

  localparam int PW = $clog2(FIFO_DEPTH);

  // Elaboration-time guard against unsupported configurations.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_params
    $error("regfile_wr_arbiter: FIFO_DEPTH must be a power of 2 >= 2 and MAX_WAIT >= 1");
  end

  // Queue storage; no reset needed, occupancy is tracked by the pointers.
  logic [REG_ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
  logic [REG_WIDTH-1:0]      data_mem [FIFO_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]             wr_ptr_reg;
  logic [PW:0]             rd_ptr_reg;
  logic [PW:0]             used;
  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    wb_req;
  logic                    force_grant;
  logic [FIFO_DEPTH-1:0]   entry_hit;

  assign used   = wr_ptr_reg - rd_ptr_reg;
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                  (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);

  // Ready depends only on registered occupancy (and reset), never on ext_valid.
  // A pop in a full cycle does not open the FIFO until the next cycle.
  assign ext_ready = rst_n & ~full;

  // Results targeting x0 are accepted and dropped.
  assign push   = ext_valid & ext_ready & (ext_rd != '0);
  assign wb_req = wb_valid & (wb_rd != '0);

`ifdef REGWR_ARB_STARVE_EN
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt_reg;

  // Count cycles the FIFO head has been refused; saturate, clear on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
    end else if (pop) begin
      wait_cnt_reg <= '0;
    end else if (!empty && (wait_cnt_reg != CW'(MAX_WAIT))) begin
      wait_cnt_reg <= wait_cnt_reg + CW'(1);
    end
  end

  assign force_grant = (wait_cnt_reg == CW'(MAX_WAIT));
`else
  assign force_grant = 1'b0;
`endif

  // Write-port grant: forced FIFO head, then WB, then FIFO head, else idle.
  always_comb begin
    RegWrite = 1'b0;
    addr_rd  = '0;
    data_rd  = '0;
    wb_stall = 1'b0;
    pop      = 1'b0;
    if (rst_n) begin
      if (force_grant && !empty) begin
        RegWrite = 1'b1;
        addr_rd  = rd_mem[rd_ptr_reg[PW-1:0]];
        data_rd  = data_mem[rd_ptr_reg[PW-1:0]];
        pop      = 1'b1;
        wb_stall = wb_req;
      end else if (wb_req) begin
        RegWrite = 1'b1;
        addr_rd  = wb_rd;
        data_rd  = wb_data;
      end else if (!empty) begin
        RegWrite = 1'b1;
        addr_rd  = rd_mem[rd_ptr_reg[PW-1:0]];
        data_rd  = data_mem[rd_ptr_reg[PW-1:0]];
        pop      = 1'b1;
      end
    end
  end

  // Advance queue pointers; reset discards everything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
      end
    end
  end

  // Capture accepted results into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg[PW-1:0]]   <= ext_rd;
      data_mem[wr_ptr_reg[PW-1:0]] <= ext_data;
    end
  end

  // Per-slot hazard match; a slot counts while it lies inside [rd_ptr, wr_ptr),
  // including the head being popped this cycle.
  genvar gi;
  for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_pend
    logic [PW-1:0] offset;
    logic          occupied;
    logic          rs1_match;
    logic          rs2_match;

    assign offset    = PW'(gi) - rd_ptr_reg[PW-1:0];
    assign occupied  = ({1'b0, offset} < used);
    assign rs1_match = (id_rs1 != '0) && (rd_mem[gi] == id_rs1);
    assign rs2_match = (id_rs2 != '0) && (rd_mem[gi] == id_rs2);
    assign entry_hit[gi] = occupied & (rs1_match | rs2_match);
  end

  assign pend_hit = rst_n & (|entry_hit);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the arbitration rules.
// Honours REGWR_ARB_STARVE_EN the same way the design does.
module tb_regfile_wr_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int MAXW  = 4;
`ifdef REGWR_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          ext_valid;
  logic          ext_ready;
  logic [AW-1:0] ext_rd;
  logic [DW-1:0] ext_data;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          pend_hit;
  logic          RegWrite;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] data_rd;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wr_arbiter #(
    .REG_ADDR_WIDTH(AW), .REG_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_rd(ext_rd), .ext_data(ext_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .pend_hit(pend_hit),
    .RegWrite(RegWrite), .addr_rd(addr_rd), .data_rd(data_rd)
  );

  always #5 clk = ~clk;

  // Reference model: the queue of pending results plus how long the head has waited.
  logic [AW-1:0] q_rd[$];
  logic [DW-1:0] q_data[$];
  int            waited = 0;

  logic          exp_we, exp_stall, exp_ready, exp_pend, exp_pop;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  logic [AW+DW+3:0] obs;
  assign obs = {RegWrite, addr_rd, data_rd, wb_stall, ext_ready, pend_hit};

  function automatic logic [AW+DW+3:0] expv();
    return {exp_we, exp_addr, exp_data, exp_stall, exp_ready, exp_pend};
  endfunction

  task automatic model_eval();
    int n;
    bit wreq;
    bit frc;
    n    = q_rd.size();
    wreq = wb_valid && (wb_rd != 0);
    frc  = STARVE && (n > 0) && (waited >= MAXW);
    exp_we = 0; exp_addr = '0; exp_data = '0; exp_stall = 0;
    exp_ready = 0; exp_pend = 0; exp_pop = 0;
    if (rst_n) begin
      exp_ready = (n < DEPTH);
      if (frc) begin
        exp_we = 1; exp_addr = q_rd[0]; exp_data = q_data[0]; exp_pop = 1; exp_stall = wreq;
      end else if (wreq) begin
        exp_we = 1; exp_addr = wb_rd; exp_data = wb_data;
      end else if (n > 0) begin
        exp_we = 1; exp_addr = q_rd[0]; exp_data = q_data[0]; exp_pop = 1;
      end
      foreach (q_rd[k]) begin
        if ((id_rs1 != 0 && q_rd[k] == id_rs1) || (id_rs2 != 0 && q_rd[k] == id_rs2)) exp_pend = 1;
      end
    end
  endtask

  task automatic model_update();
    bit acc;
    acc = ext_valid && exp_ready;
    if (exp_pop) begin
      void'(q_rd.pop_front());
      void'(q_data.pop_front());
      waited = 0;
    end else if (q_rd.size() > 0 && waited < MAXW) begin
      waited++;
    end
    if (acc && ext_rd != 0) begin
      q_rd.push_back(ext_rd);
      q_data.push_back(ext_data);
    end
  endtask

  task automatic model_clear();
    q_rd.delete();
    q_data.delete();
    waited = 0;
  endtask

  // Advance one clock: model follows the DUT at the edge, then step off the edge.
  task automatic tick();
    @(posedge clk);
    model_eval();
    if (rst_n) model_update();
    #1;
  endtask

  task automatic drive_idle();
    wb_valid = 0; wb_rd = '0; wb_data = '0;
    ext_valid = 0; ext_rd = '0; ext_data = '0;
    id_rs1 = '0; id_rs2 = '0;
  endtask

  task automatic test_reset();
    wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h1234; ext_valid = 1; ext_rd = 5'd2; id_rs1 = 5'd2;
    #1;
    model_eval(); n_cmp++;
    if (obs !== expv()) begin n_bad++; $display("FAIL reset_hold: got %h want %h", obs, expv()); end
    @(posedge clk); #1;
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      wb_valid = 1; wb_rd = 5'd9; wb_data = $urandom;
      ext_valid = (c < 2); ext_rd = 5'(20 + c); ext_data = $urandom;
      id_rs1 = 5'd20; id_rs2 = 5'd21;
      @(negedge clk); model_eval(); n_cmp++;
      if (obs !== expv()) begin n_bad++; $display("FAIL reset_fill c%0d: got %h want %h", c, obs, expv()); end
      tick();
    end
    // Mid-cycle reset with two entries queued.
    @(negedge clk); #1;
    rst_n = 0; model_clear();
    #1;
    n_cmp++;
    if ({RegWrite, ext_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_mid: RegWrite,ext_ready got %b want 00", {RegWrite, ext_ready});
    end
    model_eval(); n_cmp++;
    if (obs !== expv()) begin n_bad++; $display("FAIL reset_mid_model: got %h want %h", obs, expv()); end
    @(posedge clk); #1;
    rst_n = 1; drive_idle(); id_rs1 = 5'd20; id_rs2 = 5'd21;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); n_cmp++;
      if ({RegWrite, ext_ready, pend_hit} !== 3'b010) begin
        n_bad++; $display("FAIL reset_after c%0d: we,ready,pend got %b want 010", c, {RegWrite, ext_ready, pend_hit});
      end
      tick();
    end
  endtask

  task automatic test_idle_drain();
    drive_idle();
    ext_valid = 1; ext_rd = 5'd7; ext_data = 32'hDEAD;
    @(negedge clk); model_eval(); n_cmp++;
    if (obs !== expv()) begin n_bad++; $display("FAIL idle_push: got %h want %h", obs, expv()); end
    tick();
    drive_idle();
    @(negedge clk); n_cmp++;
    if ({RegWrite, addr_rd, data_rd} !== {1'b1, 5'd7, 32'hDEAD}) begin
      n_bad++; $display("FAIL idle_write: got %b/%0d/%h want 1/7/dead", RegWrite, addr_rd, data_rd);
    end
    tick();
    @(negedge clk); n_cmp++;
    if ({RegWrite, ext_ready} !== 2'b01) begin
      n_bad++; $display("FAIL idle_empty: we,ready got %b want 01", {RegWrite, ext_ready});
    end
    tick();
  endtask

  task automatic test_full();
    logic [DW-1:0] dc;
    bit c_pending;
    bit seen_c;
    dc = $urandom; c_pending = 0; seen_c = 0;
    drive_idle();
    for (int c = 0; c < 18; c++) begin
      wb_valid = (c < 6); wb_rd = 5'd9; wb_data = $urandom;
      if (c < 2) begin
        ext_valid = 1; ext_rd = 5'(10 + c); ext_data = $urandom;
      end else if (c == 2) begin
        ext_valid = 1; ext_rd = 5'd12; ext_data = dc; c_pending = 1;
      end else if (!c_pending) begin
        ext_valid = 0;
      end
      @(negedge clk); model_eval(); n_cmp++;
      if (obs !== expv()) begin n_bad++; $display("FAIL full c%0d: got %h want %h", c, obs, expv()); end
      if (c == 2) begin
        n_cmp++;
        if (ext_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", ext_ready); end
      end
      if (RegWrite === 1'b1 && addr_rd == 5'd12 && data_rd == dc) seen_c = 1;
      if (c_pending && exp_ready) c_pending = 0;
      tick();
    end
    n_cmp++;
    if (seen_c !== 1'b1) begin n_bad++; $display("FAIL full_held_entry: written %b want 1", seen_c); end
  endtask

  task automatic test_conflict();
    drive_idle();
    ext_valid = 1; ext_rd = 5'd3; ext_data = 32'h0000_F0F3;
    @(negedge clk); model_eval(); n_cmp++;
    if (obs !== expv()) begin n_bad++; $display("FAIL conflict_push: got %h want %h", obs, expv()); end
    tick();
    drive_idle();
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'hAAAA_0003; id_rs1 = 5'd3;
    @(negedge clk); n_cmp++;
    if ({RegWrite, addr_rd, data_rd, pend_hit} !== {1'b1, 5'd3, 32'hAAAA_0003, 1'b1}) begin
      n_bad++; $display("FAIL conflict_wb: got %b/%0d/%h/%b want 1/3/aaaa0003/1", RegWrite, addr_rd, data_rd, pend_hit);
    end
    tick();
    wb_valid = 0;
    @(negedge clk); n_cmp++;
    if ({RegWrite, addr_rd, data_rd, pend_hit} !== {1'b1, 5'd3, 32'h0000_F0F3, 1'b1}) begin
      n_bad++; $display("FAIL conflict_fifo: got %b/%0d/%h/%b want 1/3/0000f0f3/1", RegWrite, addr_rd, data_rd, pend_hit);
    end
    tick();
    @(negedge clk); n_cmp++;
    if ({RegWrite, pend_hit} !== 2'b00) begin
      n_bad++; $display("FAIL conflict_after: we,pend got %b want 00", {RegWrite, pend_hit});
    end
    tick();
  endtask

  task automatic test_rd0();
    drive_idle();
    ext_valid = 1; ext_rd = 5'd0; ext_data = 32'hBADD_0000;
    @(negedge clk); model_eval(); n_cmp++;
    if (obs !== expv()) begin n_bad++; $display("FAIL rd0_push: got %h want %h", obs, expv()); end
    tick();
    ext_valid = 1; ext_rd = 5'd6; ext_data = 32'h6666;
    @(negedge clk); n_cmp++;
    if ({RegWrite, pend_hit} !== 2'b00) begin
      n_bad++; $display("FAIL rd0_dropped: we,pend got %b want 00", {RegWrite, pend_hit});
    end
    tick();
    drive_idle();
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hBAD;
    @(negedge clk); n_cmp++;
    if ({RegWrite, addr_rd, data_rd} !== {1'b1, 5'd6, 32'h6666}) begin
      n_bad++; $display("FAIL rd0_wb_free: got %b/%0d/%h want 1/6/6666", RegWrite, addr_rd, data_rd);
    end
    tick();
    drive_idle();
    @(negedge clk); model_eval(); n_cmp++;
    if (obs !== expv()) begin n_bad++; $display("FAIL rd0_after: got %h want %h", obs, expv()); end
    tick();
  endtask

  task automatic test_starve();
    drive_idle();
    for (int c = 0; c < 10; c++) begin
      wb_valid = (c <= 7); wb_rd = 5'd5; wb_data = 32'h5000 + c;
      ext_valid = (c == 0); ext_rd = 5'd8; ext_data = 32'h8888_0000;
      id_rs1 = 5'd0; id_rs2 = 5'd8;
      @(negedge clk); model_eval(); n_cmp++;
      if (obs !== expv()) begin n_bad++; $display("FAIL starve c%0d: got %h want %h", c, obs, expv()); end
      if (c == 5) begin
        n_cmp++;
`ifdef REGWR_ARB_STARVE_EN
        if ({RegWrite, addr_rd, data_rd, wb_stall} !== {1'b1, 5'd8, 32'h8888_0000, 1'b1}) begin
          n_bad++; $display("FAIL starve_force: got %b/%0d/%h/%b want 1/8/88880000/1", RegWrite, addr_rd, data_rd, wb_stall);
        end
`else
        if ({RegWrite, addr_rd, data_rd, wb_stall} !== {1'b1, 5'd5, 32'h5005, 1'b0}) begin
          n_bad++; $display("FAIL starve_noforce: got %b/%0d/%h/%b want 1/5/5005/0", RegWrite, addr_rd, data_rd, wb_stall);
        end
`endif
      end
      if (c == 6) begin
        n_cmp++;
        if ({RegWrite, addr_rd, data_rd, wb_stall} !== {1'b1, 5'd5, 32'h5006, 1'b0}) begin
          n_bad++; $display("FAIL starve_wb_next: got %b/%0d/%h/%b want 1/5/5006/0", RegWrite, addr_rd, data_rd, wb_stall);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wb_valid  = ($urandom_range(0, 99) < 60);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      ext_valid = ($urandom_range(0, 99) < 50);
      ext_rd    = 5'($urandom_range(0, 7));
      ext_data  = $urandom;
      id_rs1    = 5'($urandom_range(0, 7));
      id_rs2    = 5'($urandom_range(0, 7));
      @(negedge clk); model_eval(); n_cmp++;
      if (obs !== expv()) begin n_bad++; $display("FAIL random c%0d: got %h want %h", c, obs, expv()); end
      tick();
    end
    drive_idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); model_eval(); n_cmp++;
      if (obs !== expv()) begin n_bad++; $display("FAIL random_drain c%0d: got %h want %h", c, obs, expv()); end
      tick();
    end
  endtask

  initial begin
    drive_idle();
    rst_n = 1;
    #1 rst_n = 0;
    test_reset();
    test_idle_drain();
    test_full();
    test_conflict();
    test_rd0();
    test_starve();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
